prog_counter_v2: RTL and testbench

PROG_COUNTER_V2 -- requirements
Module: prog_counter_v2

---
 rtl/pcnt_pkg.sv | 16 +
 rtl/pcnt_prescaler.sv | 33 +++
 rtl/prog_counter_v2.sv | 141 ++++++++++++++
 tb/tb_prog_counter_v2.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pcnt_pkg.sv
// Shared types and default sizes for the programmable up/down counter.
package pcnt_pkg;

    // Boundary behaviour; RSVD is treated exactly like WRAP.
    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2,
        RSVD    = 2'd3
    } cnt_mode_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 4;
    localparam int DEF_PRE_W  = 8;

endpackage : pcnt_pkg

// File: rtl/pcnt_prescaler.sv
// Tick divider: one tick for every div+1 cycles with en high.
// The phase holds while en is low; restart forces it back to zero.
module pcnt_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Terminal phase reached; >= keeps it safe if div shrinks mid-count.
    assign tick = en && !restart && (pre_q >= div);

    // Next phase: restart > terminal rollover > advance > hold.
    always_comb begin
        pre_d = pre_q;
        if (restart)      pre_d = '0;
        else if (tick)    pre_d = '0;
        else if (en)      pre_d = pre_q + 1'b1;
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

endmodule : pcnt_prescaler

// File: rtl/prog_counter_v2.sv
// Programmable bounded up/down counter with WRAP / SAT / ONESHOT boundary
// handling. Define PCNT_PRESCALE_EN to build the tick prescaler; without it
// every enabled cycle is a tick and pre_div is ignored.
module prog_counter_v2
    import pcnt_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W,
    parameter int PRE_W  = DEF_PRE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              enable,
    input  logic              up_down,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [WIDTH-1:0]  min_count,
    input  logic [WIDTH-1:0]  max_count,
    input  logic [STEP_W-1:0] step,
    input  logic [PRE_W-1:0]  pre_div,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              zero,
    output logic              cfg_err,
    output logic              wrap_pulse,
    output logic              done,
    output logic              overflow
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             wp_q, wp_d;

    logic      cnt_en, pre_tick, tick, restart;
    logic      is_wrap, is_oneshot;
    cnt_mode_e mode_e;

    assign mode_e     = cnt_mode_e'(mode);
    assign is_wrap    = (mode_e == WRAP) || (mode_e == RSVD);
    assign is_oneshot = (mode_e == ONESHOT);

    assign cfg_err = (min_count > max_count);
    assign restart = clear || load;
    assign cnt_en  = enable && !done_q && !cfg_err;

`ifdef PCNT_PRESCALE_EN
    pcnt_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .en      (cnt_en),
        .div     (pre_div),
        .tick    (pre_tick)
    );
`else
    logic unused_pre_div;
    assign unused_pre_div = ^pre_div;
    assign pre_tick       = 1'b1;
`endif

    assign tick = cnt_en && pre_tick;

    // One extra bit so a step past either bound is seen, not truncated.
    logic [WIDTH:0] cnt_x, step_x, min_x, max_x, sum_up, lim_dn;
    logic           up_ok, dn_ok, bnd;

    // Next-state: clear > load > tick > hold, with boundary handling.
    always_comb begin
        cnt_x   = {1'b0, count_q};
        step_x  = (WIDTH+1)'(step);
        min_x   = {1'b0, min_count};
        max_x   = {1'b0, max_count};
        sum_up  = cnt_x + step_x;
        lim_dn  = min_x + step_x;
        up_ok   = (sum_up <= max_x);
        dn_ok   = (cnt_x >= lim_dn);
        bnd     = 1'b0;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        wp_d    = 1'b0;
        if (clear) begin
            count_d = min_count;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (load) begin
            // With inverted bounds the clamp is meaningless, take the value raw.
            if (cfg_err)                   count_d = load_value;
            else if (load_value < min_count) count_d = min_count;
            else if (load_value > max_count) count_d = max_count;
            else                           count_d = load_value;
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (tick && (step != '0)) begin
            if (up_down) begin
                if (up_ok) count_d = sum_up[WIDTH-1:0];
                else begin
                    bnd     = 1'b1;
                    count_d = is_wrap ? min_count : max_count;
                end
            end else begin
                if (dn_ok) count_d = count_q - step_x[WIDTH-1:0];
                else begin
                    bnd     = 1'b1;
                    count_d = is_wrap ? max_count : min_count;
                end
            end
            if (bnd) begin
                wp_d = 1'b1;
                if (is_wrap)    ovf_d  = 1'b1;
                if (is_oneshot) done_d = 1'b1;
            end
        end
    end

    // Count and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wp_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wp_q    <= wp_d;
        end
    end

    assign count      = count_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign wrap_pulse = wp_q;
    assign tc         = up_down ? (count_q == max_count) : (count_q == min_count);
    assign zero       = (count_q == '0);

endmodule : prog_counter_v2

// File: tb/tb_prog_counter_v2.sv
// Directed bench for prog_counter_v2 with immediate-assertion checks.
module tb_prog_counter_v2;

    logic       clk = 1'b0;
    logic       rst_n, clear, load, enable, up_down;
    logic [1:0] mode;
    logic [7:0] load_value, min_count, max_count, pre_div;
    logic [3:0] step;
    logic [7:0] count;
    logic       tc, zero, cfg_err, wrap_pulse, done, overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_counter_v2 dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .enable(enable),
        .up_down(up_down), .mode(mode), .load_value(load_value),
        .min_count(min_count), .max_count(max_count), .step(step),
        .pre_div(pre_div), .count(count), .tc(tc), .zero(zero),
        .cfg_err(cfg_err), .wrap_pulse(wrap_pulse), .done(done),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 0; load = 0; enable = 0; up_down = 0;
        mode = 2'd0; load_value = 0; min_count = 0; max_count = 0;
        step = 0; pre_div = 0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_flags", {wrap_pulse, done, overflow}, 0);
        chk("rst_zero", zero, 1);
        chk("rst_tc", tc, 1);
        cyc(2);
        #3 rst_n = 1'b1;
        cyc();
        chk("post_rst_count", count, 0);

        // WRAP up, min=2 max=10 step=3, load 8
        mode = 2'd0; up_down = 1; min_count = 2; max_count = 10; step = 3;
        load_value = 8; load = 1; cyc(); load = 0;
        chk("wrap_load", count, 8);
        chk("wrap_tc0", tc, 0);
        enable = 1; cyc();
        chk("wrap_count", count, 2);
        chk("wrap_pulse", wrap_pulse, 1);
        chk("wrap_ovf", overflow, 1);
        cyc();
        chk("wrap_step", count, 5);
        chk("wrap_pulse_1cyc", wrap_pulse, 0);
        chk("wrap_ovf_sticky", overflow, 1);
        enable = 0;

        // load clamps above max
        load_value = 50; load = 1; cyc(); load = 0;
        chk("clamp_hi", count, 10);
        chk("load_clr_ovf", overflow, 0);
        chk("tc_at_max", tc, 1);

        // step=0 at max: no change, no boundary
        step = 0; enable = 1; cyc(2);
        chk("step0_count", count, 10);
        chk("step0_pulse", {wrap_pulse, overflow}, 0);

        // reserved mode behaves as WRAP
        mode = 2'd3; step = 1; cyc();
        chk("rsvd_count", count, 2);
        chk("rsvd_ovf", {wrap_pulse, overflow}, 2'b11);
        enable = 0;

        // SAT down, min=0 step=2, load 1
        mode = 2'd1; up_down = 0; min_count = 0; step = 2;
        load_value = 1; load = 1; cyc(); load = 0;
        chk("sat_load", count, 1);
        enable = 1; cyc();
        chk("sat_count", count, 0);
        chk("sat_pulse", wrap_pulse, 1);
        cyc();
        chk("sat_hold", count, 0);
        chk("sat_pulse2", wrap_pulse, 1);
        chk("sat_ovf", overflow, 0);
        chk("sat_zero_tc", {zero, tc}, 2'b11);
        enable = 0;

        // ONESHOT up, max=5 step=1, load 3
        mode = 2'd2; up_down = 1; max_count = 5; step = 1;
        load_value = 3; load = 1; cyc(); load = 0;
        enable = 1; cyc();
        chk("os_4", count, 4);
        cyc();
        chk("os_5", count, 5);
        chk("os_notdone", done, 0);
        cyc();
        chk("os_bnd_count", count, 5);
        chk("os_done", {done, wrap_pulse}, 2'b11);
        cyc(5);
        chk("os_blocked", count, 5);
        chk("os_blocked_flags", {done, wrap_pulse}, 2'b10);
        load_value = 0; load = 1; cyc(); load = 0;
        chk("os_reload", count, 0);
        chk("os_done_clr", done, 0);
        enable = 0;

`ifdef PCNT_PRESCALE_EN
        // pre_div=3: one tick per 4 enabled cycles; pause keeps phase
        mode = 2'd0; max_count = 200; pre_div = 3;
        load_value = 0; load = 1; cyc(); load = 0;
        enable = 1; cyc(3);
        chk("pre_wait", count, 0);
        cyc();
        chk("pre_tick", count, 1);
        cyc(2);
        enable = 0; cyc(2);
        chk("pre_pause", count, 1);
        enable = 1; cyc();
        chk("pre_phase_kept", count, 1);
        cyc();
        chk("pre_tick2", count, 2);
        enable = 0; pre_div = 0;
`else
        // pre_div ignored: tick every enabled cycle
        mode = 2'd0; max_count = 200; pre_div = 3;
        load_value = 0; load = 1; cyc(); load = 0;
        enable = 1; cyc();
        chk("nopre_tick", count, 1);
        cyc();
        chk("nopre_tick2", count, 2);
        enable = 0;
`endif

        // clear beats load
        min_count = 2; max_count = 10; load_value = 7;
        clear = 1; load = 1; cyc(); clear = 0; load = 0;
        chk("clear_prio", count, 2);
        enable = 1; cyc(2);
        chk("midcount", count, 4);
        // async reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", count, 0);
        enable = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rst_release", count, 0);

        // inverted bounds
        min_count = 9; max_count = 4; enable = 1; #1;
        chk("cfg_err", cfg_err, 1);
        cyc(2);
        chk("cfg_frozen", count, 0);
        load_value = 200; load = 1; cyc(); load = 0;
        chk("cfg_unclamped", count, 200);
        cyc();
        chk("cfg_frozen2", count, 200);
        enable = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_counter_v2
